// File: rtl/lcd_bus_ctrl.sv
// Sequencer for a 16-bit 8080-style LCD bus: panel power-up reset, then single
// command/data write or read strobe cycles driven from a valid/ready request port.
module lcd_bus_ctrl #(
    parameter int unsigned T_WR_LO    = 2,
    parameter int unsigned T_WR_HI    = 2,
    parameter int unsigned T_RD_LO    = 6,
    parameter int unsigned T_RD_HI    = 4,
    parameter int unsigned T_RST_LO   = 10,
    parameter int unsigned T_RST_WAIT = 120,
    parameter int unsigned CW         = 8
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rs,
    input  logic        req_rd,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic        hw_reset_req,
    input  logic        blk_en,
    output logic        busy,
    output logic        lcd_blk,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic        lcd_rst,
    output logic [15:0] lcd_dout,
    output logic        lcd_doe,
    input  logic [15:0] lcd_din
);

    typedef enum logic [2:0] {
        INIT_RST,
        RST_WAIT,
        IDLE,
        SETUP,
        STB_LO,
        STB_HI
    } state_t;

    // Zero-length phases are stretched to one cycle so every phase is observable.
    localparam logic [CW-1:0] WR_LO_E    = (T_WR_LO    == 0) ? CW'(1) : CW'(T_WR_LO);
    localparam logic [CW-1:0] WR_HI_E    = (T_WR_HI    == 0) ? CW'(1) : CW'(T_WR_HI);
    localparam logic [CW-1:0] RD_LO_E    = (T_RD_LO    == 0) ? CW'(1) : CW'(T_RD_LO);
    localparam logic [CW-1:0] RD_HI_E    = (T_RD_HI    == 0) ? CW'(1) : CW'(T_RD_HI);
    localparam logic [CW-1:0] RST_LO_E   = (T_RST_LO   == 0) ? CW'(1) : CW'(T_RST_LO);
    localparam logic [CW-1:0] RST_WAIT_E = (T_RST_WAIT == 0) ? CW'(1) : CW'(T_RST_WAIT);

    state_t        state, nstate;
    logic [CW-1:0] timer, ntimer;
    logic          rd_q;
    logic          accept;
    logic          txn_rd;
    logic          in_txn;
    logic          sample;
    logic [CW-1:0] lo_len, hi_len;

    always_comb begin
        nstate = state;
        ntimer = timer + CW'(1);
        accept = 1'b0;
        lo_len = rd_q ? RD_LO_E : WR_LO_E;
        hi_len = rd_q ? RD_HI_E : WR_HI_E;
        case (state)
            INIT_RST: begin
                if (timer >= RST_LO_E) begin
                    nstate = RST_WAIT;
                    ntimer = CW'(1);
                end
            end
            RST_WAIT: begin
                if (timer >= RST_WAIT_E) begin
                    nstate = IDLE;
                    ntimer = '0;
                end
            end
            IDLE: begin
                ntimer = '0;
                if (hw_reset_req) begin
                    nstate = INIT_RST;
                    ntimer = CW'(1);
                end else if (req_valid && req_ready) begin
                    accept = 1'b1;
                    nstate = SETUP;
                end
            end
            SETUP: begin
                nstate = STB_LO;
                ntimer = CW'(1);
            end
            STB_LO: begin
                if (timer >= lo_len) begin
                    nstate = STB_HI;
                    ntimer = CW'(1);
                end
            end
            STB_HI: begin
                if (timer >= hi_len) begin
                    nstate = IDLE;
                    ntimer = '0;
                end
            end
            default: begin
                nstate = INIT_RST;
                ntimer = '0;
            end
        endcase
    end

    // Outputs are registered from the next state; on the accept edge the
    // direction comes straight from the request since rd_q is not yet loaded.
    always_comb begin
        txn_rd = accept ? req_rd : rd_q;
        in_txn = (nstate == SETUP) || (nstate == STB_LO) || (nstate == STB_HI);
        sample = rd_q && (state == STB_LO) && (nstate == STB_HI);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state     <= INIT_RST;
            timer     <= '0;
            rd_q      <= 1'b0;
            lcd_cs    <= 1'b1;
            lcd_wr    <= 1'b1;
            lcd_rd    <= 1'b1;
            lcd_rs    <= 1'b1;
            lcd_rst   <= 1'b0;
            lcd_dout  <= '0;
            lcd_doe   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b1;
        end else begin
            state <= nstate;
            timer <= ntimer;
            if (accept) begin
                rd_q   <= req_rd;
                lcd_rs <= req_rs;
                if (!req_rd) begin
                    lcd_dout <= req_wdata;
                end
            end
            lcd_cs    <= !in_txn;
            lcd_wr    <= !((nstate == STB_LO) && !txn_rd);
            lcd_rd    <= !((nstate == STB_LO) && txn_rd);
            lcd_doe   <= in_txn && !txn_rd;
            lcd_rst   <= (nstate != INIT_RST);
            req_ready <= (nstate == IDLE);
            busy      <= (nstate != IDLE);
            rsp_valid <= sample;
            if (sample) begin
                rsp_rdata <= lcd_din;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            lcd_blk <= 1'b0;
        end else begin
            lcd_blk <= blk_en;
        end
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl: reset sequence, write, read, back-to-back
// writes, backlight, hardware reset request and prst during a read strobe.
module tb_lcd_bus_ctrl;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rs = 1'b0;
    logic        req_rd = 1'b0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        hw_reset_req = 1'b0;
    logic        blk_en = 1'b0;
    logic        busy;
    logic        lcd_blk, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst;
    logic [15:0] lcd_dout;
    logic        lcd_doe;
    logic [15:0] lcd_din = '0;

    int errors = 0;
    int checks = 0;

    lcd_bus_ctrl #(
        .T_WR_LO(2), .T_WR_HI(2), .T_RD_LO(6), .T_RD_HI(4),
        .T_RST_LO(10), .T_RST_WAIT(120), .CW(8)
    ) dut (
        .pclk(pclk), .prst(prst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rd(req_rd), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .hw_reset_req(hw_reset_req), .blk_en(blk_en), .busy(busy),
        .lcd_blk(lcd_blk), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs),
        .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_rst(lcd_rst),
        .lcd_dout(lcd_dout), .lcd_doe(lcd_doe), .lcd_din(lcd_din)
    );

    always #5 pclk = ~pclk;

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_rst, lcd_blk, lcd_doe, req_ready, rsp_valid, busy} !== 10'b1111000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b",
                     {lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_rst, lcd_blk, lcd_doe, req_ready, rsp_valid, busy}, 10'b1111000001);
        end
        checks++;
        if ({lcd_dout, rsp_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: dout=%h rdata=%h want 0", lcd_dout, rsp_rdata);
        end
        prst = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            @(posedge pclk);
            #1;
            checks++;
            if (lcd_rst !== (k >= 11)) begin
                errors++;
                $display("FAIL reset_lcd_rst cycle %0d: got %b want %b", k, lcd_rst, (k >= 11));
            end
            checks++;
            if (req_ready !== (k >= 131)) begin
                errors++;
                $display("FAIL reset_ready cycle %0d: got %b want %b", k, req_ready, (k >= 131));
            end
            checks++;
            if ({lcd_cs, lcd_wr, lcd_rd} !== 3'b111) begin
                errors++;
                $display("FAIL reset_strobes cycle %0d: cs/wr/rd=%b want 111", k, {lcd_cs, lcd_wr, lcd_rd});
            end
        end
    endtask

    task automatic test_write();
        logic ecs, ewr, edoe;
        req_valid = 1'b1; req_rs = 1'b0; req_rd = 1'b0; req_wdata = 16'h002C;
        for (int k = 1; k <= 6; k++) begin
            @(posedge pclk);
            #1;
            if (k == 1) req_valid = 1'b0;
            ecs  = !(k >= 1 && k <= 5);
            ewr  = !(k == 2 || k == 3);
            edoe = (k >= 1 && k <= 5);
            checks++;
            if ({lcd_cs, lcd_wr, lcd_rd, lcd_doe} !== {ecs, ewr, 1'b1, edoe}) begin
                errors++;
                $display("FAIL write_pins cycle %0d: cs/wr/rd/doe=%b want %b", k,
                         {lcd_cs, lcd_wr, lcd_rd, lcd_doe}, {ecs, ewr, 1'b1, edoe});
            end
            checks++;
            if (lcd_dout !== 16'h002C || lcd_rs !== 1'b0) begin
                errors++;
                $display("FAIL write_data cycle %0d: dout=%h rs=%b want 002c 0", k, lcd_dout, lcd_rs);
            end
            checks++;
            if (req_ready !== (k == 6) || busy !== (k != 6)) begin
                errors++;
                $display("FAIL write_ready cycle %0d: ready=%b busy=%b want %b %b", k, req_ready, busy, (k == 6), (k != 6));
            end
        end
    endtask

    task automatic test_read();
        logic ecs, erd;
        req_valid = 1'b1; req_rs = 1'b1; req_rd = 1'b1; req_wdata = 16'hFFFF;
        for (int k = 1; k <= 14; k++) begin
            @(posedge pclk);
            #1;
            if (k == 1) req_valid = 1'b0;
            if (k == 2) lcd_din = 16'hA55A;
            ecs = !(k >= 1 && k <= 11);
            erd = !(k >= 2 && k <= 7);
            checks++;
            if ({lcd_cs, lcd_wr, lcd_rd, lcd_doe} !== {ecs, 1'b1, erd, 1'b0}) begin
                errors++;
                $display("FAIL read_pins cycle %0d: cs/wr/rd/doe=%b want %b", k,
                         {lcd_cs, lcd_wr, lcd_rd, lcd_doe}, {ecs, 1'b1, erd, 1'b0});
            end
            checks++;
            if (rsp_valid !== (k == 8)) begin
                errors++;
                $display("FAIL read_rsp_valid cycle %0d: got %b want %b", k, rsp_valid, (k == 8));
            end
            checks++;
            if (rsp_rdata !== ((k >= 8) ? 16'hA55A : 16'h0000)) begin
                errors++;
                $display("FAIL read_rdata cycle %0d: got %h want %h", k, rsp_rdata, (k >= 8) ? 16'hA55A : 16'h0000);
            end
            if (k == 8) lcd_din = 16'h0000;
            checks++;
            if (req_ready !== (k >= 12) || lcd_dout !== 16'h002C || lcd_rs !== 1'b1) begin
                errors++;
                $display("FAIL read_misc cycle %0d: ready=%b dout=%h rs=%b want %b 002c 1", k, req_ready, lcd_dout, lcd_rs, (k >= 12));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic prev_wr = 1'b1;
        logic [15:0] edout;
        int m;
        req_valid = 1'b1; req_rs = 1'b1; req_rd = 1'b0; req_wdata = 16'h1111;
        for (int k = 1; k <= 18; k++) begin
            @(posedge pclk);
            #1;
            if (k == 1)  req_wdata = 16'h2222;
            if (k == 7)  req_wdata = 16'h3333;
            if (k == 13) req_valid = 1'b0;
            m = k % 6;
            edout = (k <= 6) ? 16'h1111 : (k <= 12) ? 16'h2222 : 16'h3333;
            if (prev_wr && !lcd_wr) pulses++;
            prev_wr = lcd_wr;
            checks++;
            if ({lcd_cs, lcd_wr, busy} !== {(m == 0), !(m == 2 || m == 3), (m != 0)}) begin
                errors++;
                $display("FAIL b2b_pins cycle %0d: cs/wr/busy=%b want %b", k,
                         {lcd_cs, lcd_wr, busy}, {(m == 0), !(m == 2 || m == 3), (m != 0)});
            end
            checks++;
            if (lcd_dout !== edout || lcd_rs !== 1'b1) begin
                errors++;
                $display("FAIL b2b_data cycle %0d: dout=%h rs=%b want %h 1", k, lcd_dout, lcd_rs, edout);
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d want 3", pulses);
        end
    endtask

    task automatic test_blk();
        blk_en = 1'b1;
        checks++;
        if (lcd_blk !== 1'b0) begin
            errors++;
            $display("FAIL blk_delay: got %b want 0", lcd_blk);
        end
        @(posedge pclk); #1;
        checks++;
        if (lcd_blk !== 1'b1) begin
            errors++;
            $display("FAIL blk_on: got %b want 1", lcd_blk);
        end
        blk_en = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (lcd_blk !== 1'b0) begin
            errors++;
            $display("FAIL blk_off: got %b want 0", lcd_blk);
        end
        blk_en = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_hw_reset();
        logic ecs, ewr;
        hw_reset_req = 1'b1;
        req_valid = 1'b1; req_rs = 1'b0; req_rd = 1'b0; req_wdata = 16'h00AB;
        for (int k = 1; k <= 137; k++) begin
            @(posedge pclk);
            #1;
            if (k == 1)   hw_reset_req = 1'b0;
            if (k == 132) req_valid = 1'b0;
            ecs = !(k >= 132 && k <= 136);
            ewr = !(k == 133 || k == 134);
            checks++;
            if (lcd_rst !== (k >= 11) || req_ready !== (k == 131 || k == 137)) begin
                errors++;
                $display("FAIL hwrst_seq cycle %0d: rst=%b ready=%b want %b %b", k, lcd_rst, req_ready,
                         (k >= 11), (k == 131 || k == 137));
            end
            checks++;
            if ({lcd_cs, lcd_wr} !== {ecs, ewr}) begin
                errors++;
                $display("FAIL hwrst_pins cycle %0d: cs/wr=%b want %b", k, {lcd_cs, lcd_wr}, {ecs, ewr});
            end
            if (k == 1) begin
                checks++;
                if (lcd_dout !== 16'h3333 || lcd_rs !== 1'b1) begin
                    errors++;
                    $display("FAIL hwrst_no_accept: dout=%h rs=%b want 3333 1", lcd_dout, lcd_rs);
                end
            end
            if (k == 132) begin
                checks++;
                if (lcd_dout !== 16'h00AB || lcd_rs !== 1'b0 || lcd_doe !== 1'b1) begin
                    errors++;
                    $display("FAIL hwrst_pending: dout=%h rs=%b doe=%b want 00ab 0 1", lcd_dout, lcd_rs, lcd_doe);
                end
            end
        end
    endtask

    task automatic test_prst_mid();
        lcd_din = 16'h1234;
        req_valid = 1'b1; req_rs = 1'b1; req_rd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge pclk);
            #1;
            if (k == 1) req_valid = 1'b0;
        end
        checks++;
        if (lcd_rd !== 1'b0 || lcd_cs !== 1'b0) begin
            errors++;
            $display("FAIL prst_in_strobe: rd=%b cs=%b want 0 0", lcd_rd, lcd_cs);
        end
        prst = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if ({lcd_cs, lcd_wr, lcd_rd, lcd_rst, lcd_doe, rsp_valid, req_ready, busy, lcd_blk} !== 9'b111000010) begin
            errors++;
            $display("FAIL prst_outputs: got %b want 111000010",
                     {lcd_cs, lcd_wr, lcd_rd, lcd_rst, lcd_doe, rsp_valid, req_ready, busy, lcd_blk});
        end
        checks++;
        if ({lcd_dout, rsp_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL prst_data: dout=%h rdata=%h want 0", lcd_dout, rsp_rdata);
        end
        @(posedge pclk); #1;
        prst = 1'b0;
        for (int k = 1; k <= 131; k++) begin
            @(posedge pclk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || lcd_rst !== (k >= 11) || req_ready !== (k == 131)) begin
                errors++;
                $display("FAIL prst_restart cycle %0d: rsp_valid=%b rst=%b ready=%b want 0 %b %b",
                         k, rsp_valid, lcd_rst, req_ready, (k >= 11), (k == 131));
            end
            if (k == 1) begin
                checks++;
                if (lcd_blk !== 1'b1) begin
                    errors++;
                    $display("FAIL prst_blk_resume: got %b want 1", lcd_blk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_blk();
        test_hw_reset();
        test_prst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
